dmem_region_bus: RTL and testbench
==================================

// Module: dmem_region_bus
// PURPOSE
//  Parametrised data-memory interconnect between riscv_core dmem port and NUM_REGIONS targets.
//  Decodes each access by address into contiguous 2^REGION_BITS-byte regions, steers registered read data back.
//  Adds a sim-exit (tohost) register, sticky bus-fault capture and a run-cycle counter.
//  Sits in top between core dmem_* and dualport_ram port B (plus further RAM/peripheral targets).
// PARAMETERS
//  NUM_REGIONS  2             number of decoded targets, 1..8
//  REGION_BITS  15            log2 region size in bytes; region i = [i<<REGION_BITS, (i+1)<<REGION_BITS)
//  TOHOST_ADDR  32'h8000_0000 word address of sim-exit register (must not fall inside any region)
// PORTS
//  clk          in   1               single clock, rising edge
//  rst          in   1               synchronous, active-high reset
//  dmem_addr    in   32              core byte address
//  dmem_op      in   2               00 idle, 01 read, 10 write, 11 reserved
//  dmem_data_i  in   32              core write data
//  dmem_data_o  out  32              read data to core, valid 1 cycle after read
//  tgt_addr     out  REGION_BITS     offset within region = dmem_addr[REGION_BITS-1:0]
//  tgt_cs       out  NUM_REGIONS     one-hot chip select
//  tgt_op       out  2               dmem_op forwarded (00 when no cs asserted)
//  tgt_wdata    out  32              dmem_data_i forwarded
//  tgt_rdata    in   32*NUM_REGIONS  target read data, region i at [32*i+31:32*i]
//  done         out  1               sticky: tohost written
//  exit_code    out  32              data of first tohost write
//  fault        out  1               sticky: unmapped or reserved access seen
//  fault_addr   out  32              address of first fault
//  run_cycles   out  32              cycles since reset release, frozen at done
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): done=0, exit_code=0, fault=0, fault_addr=0, run_cycles=0,
//   pending-read cleared -> dmem_data_o=0 from next cycle. Reset mid-read discards it.
//  Decode (combinational, same cycle): hit_i = op in {01,10} && dmem_addr[31:REGION_BITS]==i, i<NUM_REGIONS.
//   tgt_cs = one-hot hit; tgt_op = op if any hit else 00; tgt_addr/tgt_wdata always passthrough.
//  Tohost hit = op in {01,10} && dmem_addr[31:2]==TOHOST_ADDR[31:2]; never asserts tgt_cs.
//  Read return (latency 1): on read at edge t register source {region idx | tohost | none};
//   during t+1 dmem_data_o = tgt_rdata[idx], or exit_code for tohost, or 0 for none/unmapped.
//   No read at t -> dmem_data_o=0 during t+1. Back-to-back reads each return next cycle, no bubbles.
//  Write to tohost: if done==0 -> done<=1, exit_code<=dmem_data_i; later tohost writes ignored.
//  Fault: op in {01,10} with no region and no tohost hit, or op==11 -> fault<=1;
//   fault_addr<=dmem_addr only if fault was 0 (first fault wins). Faulting access drives no cs.
//  run_cycles: +1 each non-reset cycle while done==0; stops the cycle done is set
//   (value includes the tohost-write cycle); wraps 32'hFFFF_FFFF->0.
//  Simultaneous: one access per cycle, so fault and done cannot set together; read of
//   tohost in cycle done sets returns old exit_code (only a write can set done, so n/a).
//  Address above NUM_REGIONS<<REGION_BITS but below TOHOST is unmapped -> fault.
// TESTING
//  1 NUM_REGIONS=2: write 0xDEADBEEF @0x0000_8004 -> tgt_cs=2'b10, tgt_addr=0x0004, tgt_op=10; no fault.
//  2 reads @0x10 then @0x8010 consecutive, tgt_rdata={0x2222_2222,0x1111_1111} ->
//    dmem_data_o 0x1111_1111 then 0x2222_2222 on next two cycles, then 0.
//  3 write 0x1 @0x8000_0000 after 100 run cycles -> done=1, exit_code=1, run_cycles frozen at 101;
//    second write 0x5 -> exit_code stays 1.
//  4 read @0x0001_0000 then op=11 @0x40 -> fault=1, fault_addr=0x0001_0000, dmem_data_o=0, tgt_cs=0.
//  5 assert rst during cycle after a read issue -> dmem_data_o=0, all sticky outputs cleared next cycle.

Source files
------------

// File: rtl/dmem_region_bus.sv
// Data-memory interconnect between the core dmem port and NUM_REGIONS targets.
// Decodes each access into a contiguous 2^REGION_BITS-byte region, returns registered
// read data one cycle later, and hosts the sim-exit (tohost) register, sticky bus-fault
// capture and a run-cycle counter that freezes once the program signals completion.
module dmem_region_bus #(
    parameter int          NUM_REGIONS = 2,
    parameter int          REGION_BITS = 15,
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               dmem_addr,
    input  logic [1:0]                dmem_op,
    input  logic [31:0]               dmem_data_i,
    output logic [31:0]               dmem_data_o,
    output logic [REGION_BITS-1:0]    tgt_addr,
    output logic [NUM_REGIONS-1:0]    tgt_cs,
    output logic [1:0]                tgt_op,
    output logic [31:0]               tgt_wdata,
    input  logic [32*NUM_REGIONS-1:0] tgt_rdata,
    output logic                      done,
    output logic [31:0]               exit_code,
    output logic                      fault,
    output logic [31:0]               fault_addr,
    output logic [31:0]               run_cycles
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int TAG_W = 32 - REGION_BITS;

    // Where the data for the read issued last cycle comes from.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_REGION,
        SRC_TOHOST
    } srcKindE;

    logic                   opAccess;
    logic                   tohostHit;
    logic                   anyHit;
    logic                   faultNow;
    logic [NUM_REGIONS-1:0] hit;
    logic [IDX_W-1:0]       hitIdx;

    srcKindE                srcKind_q, srcKind_d;
    logic [IDX_W-1:0]       srcIdx_q, srcIdx_d;
    logic                   done_q, done_d;
    logic [31:0]            exitCode_q, exitCode_d;
    logic                   fault_q, fault_d;
    logic [31:0]            faultAddr_q, faultAddr_d;
    logic [31:0]            runCycles_q, runCycles_d;

    // Same-cycle address decode; reserved op 11 never selects a target.
    always_comb begin
        opAccess  = (dmem_op == 2'b01) || (dmem_op == 2'b10);
        tohostHit = opAccess && (dmem_addr[31:2] == TOHOST_ADDR[31:2]);
        hit       = '0;
        hitIdx    = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (opAccess && (dmem_addr[31:REGION_BITS] == TAG_W'(i))) begin
                hit[i] = 1'b1;
                hitIdx = IDX_W'(i);
            end
        end
        anyHit   = |hit;
        faultNow = (dmem_op == 2'b11) || (opAccess && !anyHit && !tohostHit);
    end

    assign tgt_cs    = hit;
    assign tgt_op    = anyHit ? dmem_op : 2'b00;
    assign tgt_addr  = dmem_addr[REGION_BITS-1:0];
    assign tgt_wdata = dmem_data_i;

    // Next-state for the read-return source, sticky status and the cycle counter.
    always_comb begin
        srcKind_d   = SRC_NONE;
        srcIdx_d    = srcIdx_q;
        done_d      = done_q;
        exitCode_d  = exitCode_q;
        fault_d     = fault_q;
        faultAddr_d = faultAddr_q;
        runCycles_d = done_q ? runCycles_q : runCycles_q + 32'd1;

        if (dmem_op == 2'b01) begin
            if (anyHit) begin
                srcKind_d = SRC_REGION;
                srcIdx_d  = hitIdx;
            end else if (tohostHit) begin
                srcKind_d = SRC_TOHOST;
            end
        end

        if ((dmem_op == 2'b10) && tohostHit && !done_q) begin
            done_d     = 1'b1;
            exitCode_d = dmem_data_i;
        end

        if (faultNow) begin
            fault_d = 1'b1;
            if (!fault_q) begin
                faultAddr_d = dmem_addr;
            end
        end
    end

    // State registers; reset also drops any read that was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            srcKind_q   <= SRC_NONE;
            srcIdx_q    <= '0;
            done_q      <= 1'b0;
            exitCode_q  <= '0;
            fault_q     <= 1'b0;
            faultAddr_q <= '0;
            runCycles_q <= '0;
        end else begin
            srcKind_q   <= srcKind_d;
            srcIdx_q    <= srcIdx_d;
            done_q      <= done_d;
            exitCode_q  <= exitCode_d;
            fault_q     <= fault_d;
            faultAddr_q <= faultAddr_d;
            runCycles_q <= runCycles_d;
        end
    end

    // Steer the registered read source back to the core; unmapped reads return zero.
    always_comb begin
        dmem_data_o = '0;
        case (srcKind_q)
            SRC_REGION: begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (srcIdx_q == IDX_W'(i)) begin
                        dmem_data_o = tgt_rdata[32*i +: 32];
                    end
                end
            end
            SRC_TOHOST: dmem_data_o = exitCode_q;
            default:    dmem_data_o = '0;
        endcase
    end

    assign done       = done_q;
    assign exit_code  = exitCode_q;
    assign fault      = fault_q;
    assign fault_addr = faultAddr_q;
    assign run_cycles = runCycles_q;

endmodule

// File: tb/tb_dmem_region_bus.sv
// Scoreboard bench for dmem_region_bus: the driver pushes hand-computed expectations,
// each tagged with the cycle in which it must hold, and a monitor pops and compares them.
module tb_dmem_region_bus;

    localparam int S_DATA  = 0;
    localparam int S_CS    = 1;
    localparam int S_OP    = 2;
    localparam int S_ADDR  = 3;
    localparam int S_WDATA = 4;
    localparam int S_DONE  = 5;
    localparam int S_EXIT  = 6;
    localparam int S_FAULT = 7;
    localparam int S_FADDR = 8;
    localparam int S_RUN   = 9;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } expT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [1:0]  dmem_op;
    logic [31:0] dmem_data_i;
    logic [31:0] dmem_data_o;
    logic [14:0] tgt_addr;
    logic [1:0]  tgt_cs;
    logic [1:0]  tgt_op;
    logic [31:0] tgt_wdata;
    logic [63:0] tgtRdata;
    logic        done;
    logic [31:0] exit_code;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] run_cycles;

    expT sb[$];
    int  cyc       = 0;
    int  total     = 0;
    int  bad       = 0;
    int  stimCount = 0;

    dmem_region_bus #(
        .NUM_REGIONS(2),
        .REGION_BITS(15),
        .TOHOST_ADDR(32'h8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dmem_addr(dmem_addr),
        .dmem_op(dmem_op),
        .dmem_data_i(dmem_data_i),
        .dmem_data_o(dmem_data_o),
        .tgt_addr(tgt_addr),
        .tgt_cs(tgt_cs),
        .tgt_op(tgt_op),
        .tgt_wdata(tgt_wdata),
        .tgt_rdata(tgtRdata),
        .done(done),
        .exit_code(exit_code),
        .fault(fault),
        .fault_addr(fault_addr),
        .run_cycles(run_cycles)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_DATA:  return dmem_data_o;
            S_CS:    return {30'd0, tgt_cs};
            S_OP:    return {30'd0, tgt_op};
            S_ADDR:  return {17'd0, tgt_addr};
            S_WDATA: return tgt_wdata;
            S_DONE:  return {31'd0, done};
            S_EXIT:  return exit_code;
            S_FAULT: return {31'd0, fault};
            S_FADDR: return fault_addr;
            default: return run_cycles;
        endcase
    endfunction

    // Drives one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic r, input logic [1:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        rst         = r;
        dmem_op     = op;
        dmem_addr   = addr;
        dmem_data_i = wdata;
        if (r) stimCount = 0;
        else   stimCount++;
    endtask

    // Queues an expectation for the current cycle (lag 0) or the following one (lag 1).
    task automatic checkOutput(input int sel, input logic [31:0] exp, input int lag,
                               input string name);
        expT e;
        e.due  = cyc + lag;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: on each falling edge, compare every expectation due by now.
    initial begin
        expT         e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e   = sb.pop_front();
                act = actual(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             e.name, act, e.exp, cyc);
                end
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus.
    initial begin
        tgtRdata    = {32'h2222_2222, 32'h1111_1111};
        rst         = 1'b1;
        dmem_op     = 2'b00;
        dmem_addr   = '0;
        dmem_data_i = '0;

        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0);

        // Reset state plus a write into region 1.
        applyStimulus(1'b0, 2'b10, 32'h0000_8004, 32'hDEAD_BEEF);
        checkOutput(S_DATA,  32'h0, 0, "rst_data");
        checkOutput(S_DONE,  32'h0, 0, "rst_done");
        checkOutput(S_EXIT,  32'h0, 0, "rst_exit");
        checkOutput(S_FAULT, 32'h0, 0, "rst_fault");
        checkOutput(S_FADDR, 32'h0, 0, "rst_faddr");
        checkOutput(S_RUN,   32'h0, 0, "rst_run");
        checkOutput(S_CS,    32'h2, 0, "wr_cs");
        checkOutput(S_OP,    32'h2, 0, "wr_op");
        checkOutput(S_ADDR,  32'h4, 0, "wr_addr");
        checkOutput(S_WDATA, 32'hDEAD_BEEF, 0, "wr_wdata");
        checkOutput(S_FAULT, 32'h0, 1, "wr_nofault");
        checkOutput(S_DATA,  32'h0, 1, "wr_nodata");

        // Back-to-back reads across both regions, including the top word of region 1.
        applyStimulus(1'b0, 2'b01, 32'h0000_0010, 32'h0);
        checkOutput(S_CS,   32'h1, 0, "rd0_cs");
        checkOutput(S_OP,   32'h1, 0, "rd0_op");
        checkOutput(S_DATA, 32'h1111_1111, 1, "rd0_data");
        applyStimulus(1'b0, 2'b01, 32'h0000_8010, 32'h0);
        checkOutput(S_CS,   32'h2, 0, "rd1_cs");
        checkOutput(S_DATA, 32'h2222_2222, 1, "rd1_data");
        applyStimulus(1'b0, 2'b01, 32'h0000_FFFC, 32'h0);
        checkOutput(S_CS,   32'h2, 0, "rdtop_cs");
        checkOutput(S_ADDR, 32'h7FFC, 0, "rdtop_addr");
        checkOutput(S_DATA, 32'h2222_2222, 1, "rdtop_data");
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        checkOutput(S_CS,   32'h0, 0, "idle_cs");
        checkOutput(S_OP,   32'h0, 0, "idle_op");
        checkOutput(S_DATA, 32'h0, 1, "idle_data");

        // Idle until 100 run cycles have elapsed, then signal exit through tohost.
        while (stimCount < 100) applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        applyStimulus(1'b0, 2'b10, 32'h8000_0000, 32'h1);
        checkOutput(S_RUN,   32'd100, 0, "pre_exit_run");
        checkOutput(S_CS,    32'h0, 0, "tohost_cs");
        checkOutput(S_OP,    32'h0, 0, "tohost_op");
        checkOutput(S_DONE,  32'h1, 1, "exit_done");
        checkOutput(S_EXIT,  32'h1, 1, "exit_code");
        checkOutput(S_RUN,   32'd101, 1, "exit_run");
        checkOutput(S_FAULT, 32'h0, 1, "exit_nofault");
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        checkOutput(S_RUN,   32'd101, 1, "run_frozen");
        applyStimulus(1'b0, 2'b10, 32'h8000_0000, 32'h5);
        checkOutput(S_EXIT,  32'h1, 1, "exit_kept");
        checkOutput(S_DONE,  32'h1, 1, "done_kept");
        checkOutput(S_RUN,   32'd101, 1, "run_frozen2");
        applyStimulus(1'b0, 2'b01, 32'h8000_0002, 32'h0);
        checkOutput(S_CS,    32'h0, 0, "rdhost_cs");
        checkOutput(S_DATA,  32'h1, 1, "rdhost_data");

        // Unmapped read followed by a reserved op; the first fault address sticks.
        applyStimulus(1'b0, 2'b01, 32'h0001_0000, 32'h0);
        checkOutput(S_CS,    32'h0, 0, "unmap_cs");
        checkOutput(S_OP,    32'h0, 0, "unmap_op");
        checkOutput(S_FAULT, 32'h1, 1, "unmap_fault");
        checkOutput(S_FADDR, 32'h0001_0000, 1, "unmap_faddr");
        checkOutput(S_DATA,  32'h0, 1, "unmap_data");
        applyStimulus(1'b0, 2'b11, 32'h0000_0040, 32'h0);
        checkOutput(S_CS,    32'h0, 0, "rsv_cs");
        checkOutput(S_OP,    32'h0, 0, "rsv_op");
        checkOutput(S_FAULT, 32'h1, 1, "rsv_fault");
        checkOutput(S_FADDR, 32'h0001_0000, 1, "rsv_faddr");
        checkOutput(S_DATA,  32'h0, 1, "rsv_data");

        // Reset while a read is returning and another is being issued.
        applyStimulus(1'b0, 2'b01, 32'h0000_0010, 32'h0);
        checkOutput(S_CS,    32'h1, 0, "prerst_cs");
        applyStimulus(1'b1, 2'b01, 32'h0000_8010, 32'h0);
        checkOutput(S_DATA,  32'h0, 1, "mrst_data");
        checkOutput(S_DONE,  32'h0, 1, "mrst_done");
        checkOutput(S_EXIT,  32'h0, 1, "mrst_exit");
        checkOutput(S_FAULT, 32'h0, 1, "mrst_fault");
        checkOutput(S_FADDR, 32'h0, 1, "mrst_faddr");
        checkOutput(S_RUN,   32'h0, 1, "mrst_run");
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        checkOutput(S_RUN,   32'h1, 1, "post_rst_run");
        checkOutput(S_DATA,  32'h0, 1, "post_rst_data");

        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            bad = bad + sb.size();
            total = total + sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
